// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline types: FSM state, scoreboard entry, register address width
package cpu_pkg;

  localparam int REG_FILE_ADDR_LEN = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic                         valid;
    logic                         wb_en;
    logic                         is_load;
    logic [REG_FILE_ADDR_LEN-1:0] dest;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  // An entry blocks a source only if it is live, will write back, and targets that register.
  function automatic logic entry_hit(input sb_entry_t e, input logic use_src,
                                     input logic [REG_FILE_ADDR_LEN-1:0] src);
    return use_src && e.valid && e.wb_en && (e.dest == src);
  endfunction

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - compares one ID source against the EX/MEM/WB scoreboard entries
module sb_match
  import cpu_pkg::*;
(
  input  logic                         use_src,
  input  logic [REG_FILE_ADDR_LEN-1:0] src,
  input  sb_entry_t                    ex,
  input  sb_entry_t                    mem,
  input  sb_entry_t                    wb,
  output logic [2:0]                   hit,
  output logic [2:0]                   load_hit
);

  // Bit 0 = EX, bit 1 = MEM, bit 2 = WB.
  assign hit      = {entry_hit(wb, use_src, src), entry_hit(mem, use_src, src), entry_hit(ex, use_src, src)};
  // Same hits, restricted to entries that are loads (data not ready until after MEM).
  assign load_hit = hit & {wb.is_load, mem.is_load, ex.is_load};

endmodule

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - pipeline hazard scheduler; HAZARD_FWD_EN selects load-use-only stalls
module hazard_sched
  import cpu_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYC = 8'd200
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REG_FILE_ADDR_LEN-1:0] src1,
  input  logic [REG_FILE_ADDR_LEN-1:0] src2,
  input  logic                         use_src1,
  input  logic                         use_src2,
  input  logic                         id_wb_en,
  input  logic [REG_FILE_ADDR_LEN-1:0] id_dest,
  input  logic                         id_mem_r_en,
  input  logic                         br_taken,
  input  logic                         mem_req,
  input  logic                         mem_ack,
  output logic                         hazard_detected,
  output logic                         pc_freeze,
  output logic                         ifid_flush,
  output logic                         mem_stall,
  output logic                         mem_timeout,
  output logic [1:0]                   state
);

`ifdef HAZARD_FWD_EN
  // Forwarding covers everything except a load whose data is still in EX.
  localparam logic [2:0] ANY_MASK  = 3'b000;
  localparam logic [2:0] LOAD_MASK = 3'b001;
`else
  // No forwarding: any in-flight writer of a read register blocks ID.
  localparam logic [2:0] ANY_MASK  = 3'b111;
  localparam logic [2:0] LOAD_MASK = 3'b000;
`endif

  state_t     st;
  sb_entry_t  sb_ex, sb_mem, sb_wb;
  sb_entry_t  id_entry;
  logic [2:0] hit1, hit2, lhit1, lhit2;
  logic       raw_hazard;
  logic       mem_miss;
  logic [7:0] wait_cnt;
  logic [7:0] cnt_inc;

  sb_match u_match_src1 (
    .use_src  (use_src1),
    .src      (src1),
    .ex       (sb_ex),
    .mem      (sb_mem),
    .wb       (sb_wb),
    .hit      (hit1),
    .load_hit (lhit1)
  );

  sb_match u_match_src2 (
    .use_src  (use_src2),
    .src      (src2),
    .ex       (sb_ex),
    .mem      (sb_mem),
    .wb       (sb_wb),
    .hit      (hit2),
    .load_hit (lhit2)
  );

  assign raw_hazard      = (|((hit1 | hit2) & ANY_MASK)) | (|((lhit1 | lhit2) & LOAD_MASK));
  assign hazard_detected = (st == ST_RUN) && id_valid && raw_hazard;
  assign pc_freeze       = hazard_detected | mem_stall;
  assign mem_miss        = mem_req & ~mem_ack;
  assign cnt_inc         = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
  assign state           = st;

  // Build the EX entry from ID; bubbles (stall, empty ID, squashed slot) enter as invalid.
  always_comb begin
    id_entry         = SB_EMPTY;
    id_entry.valid   = id_valid && !hazard_detected && (st != ST_FLUSH);
    id_entry.wb_en   = id_wb_en;
    id_entry.is_load = id_mem_r_en;
    id_entry.dest    = id_dest;
  end

  // Scoreboard advances with the pipeline and freezes while memory is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_ex  <= SB_EMPTY;
      sb_mem <= SB_EMPTY;
      sb_wb  <= SB_EMPTY;
    end else if (!mem_stall) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= id_entry;
    end
  end

  // Control FSM with registered flush/stall outputs, wait counter and sticky timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= ST_RUN;
      ifid_flush  <= 1'b0;
      mem_stall   <= 1'b0;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      ifid_flush <= 1'b0;
      mem_stall  <= 1'b0;
      case (st)
        ST_RUN: begin
          // Memory miss outranks a branch taken in the same cycle.
          if (mem_miss) begin
            st        <= ST_MEM_WAIT;
            mem_stall <= 1'b1;
            wait_cnt  <= 8'd0;
          end else if (br_taken && !hazard_detected && !mem_stall) begin
            st         <= ST_FLUSH;
            ifid_flush <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (mem_miss) begin
            st        <= ST_MEM_WAIT;
            mem_stall <= 1'b1;
            wait_cnt  <= 8'd0;
          end else begin
            st <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          wait_cnt <= cnt_inc;
          if (cnt_inc == TIMEOUT_CYC) mem_timeout <= 1'b1;
          if (mem_ack) begin
            st <= ST_RUN;
          end else begin
            mem_stall <= 1'b1;
          end
        end
        default: st <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - directed plus randomized checks of hazard_sched against a behavioural model
module tb_hazard_sched;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int TOUT = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, use_src1, use_src2, id_wb_en, id_mem_r_en;
  logic       br_taken, mem_req, mem_ack;
  logic [3:0] src1, src2, id_dest;
  logic       hazard_detected, pc_freeze, ifid_flush, mem_stall, mem_timeout;
  logic [1:0] state;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int dest;
    bit wb;
    bit ld;
    int age;   // 1 = one stage past ID, 3 = last stage that can still block
  } rec_t;

  rec_t fl[$];
  int   m_mode;  // 0 run, 1 flush, 2 memory wait
  int   m_cnt;
  bit   m_tout;

  logic       o_haz, o_stall, o_flush, o_tout;
  logic [1:0] o_state;

  hazard_sched #(.TIMEOUT_CYC(8'(TOUT))) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .src1            (src1),
    .src2            (src2),
    .use_src1        (use_src1),
    .use_src2        (use_src2),
    .id_wb_en        (id_wb_en),
    .id_dest         (id_dest),
    .id_mem_r_en     (id_mem_r_en),
    .br_taken        (br_taken),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .hazard_detected (hazard_detected),
    .pc_freeze       (pc_freeze),
    .ifid_flush      (ifid_flush),
    .mem_stall       (mem_stall),
    .mem_timeout     (mem_timeout),
    .state           (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard();
    if (m_mode != 0 || !id_valid) return 1'b0;
    foreach (fl[i]) begin
      if (!fl[i].wb) continue;
      if (FWD && !(fl[i].age == 1 && fl[i].ld)) continue;
      if ((use_src1 && fl[i].dest == int'(src1)) || (use_src2 && fl[i].dest == int'(src2)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_tout = 1'b0;
    fl.delete();
  endtask

  task automatic model_update(input bit h);
    bit   miss;
    rec_t nq[$];
    miss = mem_req && !mem_ack;
    if (m_mode != 2) begin
      foreach (fl[i]) begin
        if (fl[i].age < 3) begin
          rec_t r;
          r = fl[i];
          r.age = r.age + 1;
          nq.push_back(r);
        end
      end
      fl = nq;
      if (id_valid && !h && m_mode != 1)
        fl.push_back('{dest: int'(id_dest), wb: id_wb_en, ld: id_mem_r_en, age: 1});
    end
    case (m_mode)
      0: begin
        if (miss) begin m_mode = 2; m_cnt = 0; end
        else if (br_taken && !h) m_mode = 1;
      end
      1: begin
        if (miss) begin m_mode = 2; m_cnt = 0; end
        else m_mode = 0;
      end
      default: begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt == TOUT) m_tout = 1'b1;
        if (mem_ack) m_mode = 0;
      end
    endcase
  endtask

  // Sample at the falling edge, compare with the model, then advance the model across the next rising edge.
  task automatic cycle();
    bit h;
    @(negedge clk);
    h       = model_hazard();
    o_haz   = hazard_detected;
    o_stall = mem_stall;
    o_flush = ifid_flush;
    o_tout  = mem_timeout;
    o_state = state;
    check("hazard_detected", 8'(hazard_detected), 8'(h));
    check("pc_freeze", 8'(pc_freeze), 8'(h || m_mode == 2));
    check("ifid_flush", 8'(ifid_flush), 8'(m_mode == 1));
    check("mem_stall", 8'(mem_stall), 8'(m_mode == 2));
    check("mem_timeout", 8'(mem_timeout), 8'(m_tout));
    check("state", 8'(state), 8'(m_mode));
    model_update(h);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_state", 8'(state), 8'd0);
    check("rst_mem_stall", 8'(mem_stall), 8'd0);
    check("rst_mem_timeout", 8'(mem_timeout), 8'd0);
    check("rst_ifid_flush", 8'(ifid_flush), 8'd0);
    check("rst_hazard", 8'(hazard_detected), 8'd0);
    check("rst_pc_freeze", 8'(pc_freeze), 8'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic set_id(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                        input bit wb, input int d, input bit ld);
    id_valid    = v;
    src1        = 4'(s1);
    use_src1    = u1;
    src2        = 4'(s2);
    use_src2    = u2;
    id_wb_en    = wb;
    id_dest     = 4'(d);
    id_mem_r_en = ld;
  endtask

  task automatic set_ctl(input bit br, input bit rq, input bit ak);
    br_taken = br;
    mem_req  = rq;
    mem_ack  = ak;
  endtask

  initial begin
    int cnt;
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_ctl(0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // ALU write R5 followed by a reader of R5
    set_id(1, 0, 0, 0, 0, 1, 5, 0);
    cycle();
    set_id(1, 5, 1, 0, 0, 0, 9, 0);
    cnt = 0;
    repeat (5) begin cycle(); cnt += int'(o_haz); end
    check("alu_raw_stall_cycles", 8'(cnt), FWD ? 8'd0 : 8'd3);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // Load R3 followed by a reader of R3
    set_id(1, 0, 0, 0, 0, 1, 3, 1);
    cycle();
    set_id(1, 3, 1, 0, 0, 0, 0, 0);
    cycle();
    check("load_use_first", 8'(o_haz), 8'd1);
    cnt = int'(o_haz);
    repeat (4) begin cycle(); cnt += int'(o_haz); end
    check("load_use_stall_cycles", 8'(cnt), FWD ? 8'd1 : 8'd3);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // Taken branch with a clean ID
    set_ctl(1, 0, 0);
    cycle();
    set_ctl(0, 0, 0);
    cycle();
    check("flush_pulse", 8'(o_flush), 8'd1);
    check("flush_state", 8'(o_state), 8'd1);
    cycle();
    check("flush_done", 8'(o_flush), 8'd0);
    check("flush_back_run", 8'(o_state), 8'd0);

    // Memory wait acked on the fourth wait cycle, scoreboard must hold R7
    set_id(1, 0, 0, 0, 0, 1, 7, 0);
    set_ctl(0, 1, 0);
    cycle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cnt = 0;
    repeat (3) begin cycle(); cnt += int'(o_stall); end
    set_ctl(0, 1, 1);
    cycle();
    cnt += int'(o_stall);
    set_ctl(0, 0, 0);
    cycle();
    check("mem_stall_cycles", 8'(cnt), 8'd4);
    check("mem_wait_exit", 8'(o_state), 8'd0);
    set_id(1, 7, 1, 0, 0, 0, 0, 0);
    cycle();
    check("sb_held_through_stall", 8'(o_haz), FWD ? 8'd0 : 8'd1);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // Unacked wait runs into the timeout, which stays set after the ack
    set_ctl(0, 1, 0);
    cycle();
    repeat (5) cycle();
    check("timeout_not_yet", 8'(o_tout), 8'd0);
    cycle();
    check("timeout_set", 8'(o_tout), 8'd1);
    set_ctl(0, 0, 1);
    cycle();
    set_ctl(0, 0, 0);
    cycle();
    check("timeout_sticky", 8'(o_tout), 8'd1);
    check("timeout_exit_run", 8'(o_state), 8'd0);

    // Reset while waiting on memory
    set_ctl(0, 1, 0);
    cycle();
    cycle();
    check("in_mem_wait", 8'(o_state), 8'd2);
    do_reset();
    set_ctl(0, 0, 0);

    // Randomized traffic with occasional resets
    repeat (800) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      set_id($urandom_range(0, 3) != 0,
             int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
             $urandom_range(0, 2) == 0);
      set_ctl($urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 2) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 8'd200: MEM_WAIT cycles before mem_timeout is raised.
REQ-002 SHALL have ports: clk  in  1  pipeline clock; rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: id_valid  in  1  ID holds a real instruction; src1, src2  in  4  ID source register addresses; use_src1, use_src2  in  1  source is actually read.
REQ-004 SHALL have ports: id_wb_en  in  1  ID instruction writes back; id_dest  in  4  ID destination; id_mem_r_en  in  1  ID instruction is a load.
REQ-005 SHALL have ports: br_taken  in  1  branch resolved taken in ID; mem_req  in  1  MEM stage access pending; mem_ack  in  1  memory completes access.
REQ-006 SHALL have ports: hazard_detected  out  1  bubble ID into EX; pc_freeze  out  1  hold PC and IF/ID; ifid_flush  out  1  squash IF/ID; mem_stall  out  1  freeze all stages; mem_timeout  out  1  sticky wait timeout; state  out  2  FSM state.

Function
REQ-007 SHALL keep a 3-entry scoreboard (EX, MEM, WB), each {valid, wb_en, is_load, dest}.
REQ-008 SHALL shift the scoreboard once per clock when mem_stall=0: EX<=ID info, MEM<=EX, WB<=MEM; when mem_stall=1 it SHALL hold.
REQ-009 SHALL load EX valid=0 when hazard_detected=1, id_valid=0 or FSM is FLUSH.
REQ-010 SHALL compute a match for srcN as: useN && entry.valid && entry.wb_en && entry.dest==srcN.
REQ-011 SHALL drive hazard_detected combinationally, only in RUN with id_valid=1; the set of entries that can match is defined in REQ-021/REQ-022.
REQ-012 SHALL drive pc_freeze = hazard_detected | mem_stall.
REQ-013 SHALL ignore br_taken while hazard_detected=1 or mem_stall=1.
REQ-014 SHALL assert ifid_flush for exactly one cycle when accepted br_taken=1 in RUN, moving to FLUSH.
REQ-015 SHALL return from FLUSH to RUN after one cycle; hazard_detected=0 in FLUSH.
REQ-016 SHALL move from RUN or FLUSH to MEM_WAIT when mem_req=1 and mem_ack=0; mem_req with mem_ack in the same cycle SHALL cause no stall.
REQ-017 SHALL hold mem_stall=1 throughout MEM_WAIT and return to RUN on the cycle after mem_ack=1.
REQ-018 SHALL count MEM_WAIT cycles in an 8-bit saturating counter, cleared on MEM_WAIT entry; when count==TIMEOUT_CYC it SHALL set mem_timeout, sticky until reset.
REQ-019 SHALL encode state as RUN=0, FLUSH=1, MEM_WAIT=2; value 3 SHALL go to RUN.
REQ-020 SHALL apply priority mem_stall > hazard_detected > ifid_flush.

Configuration
REQ-021 With HAZARD_FWD_EN defined, SHALL raise hazard_detected only on an EX entry match with is_load=1 (load-use; a one-cycle bubble).
REQ-022 Without HAZARD_FWD_EN, SHALL raise hazard_detected on any match in EX, MEM or WB (no forwarding; up to a three-cycle stall).

Reset
REQ-023 On rst=0 SHALL asynchronously force state=RUN, all scoreboard valid=0, counter=0, mem_timeout=0.
REQ-024 SHALL drive hazard_detected=0, pc_freeze=0, ifid_flush=0 and mem_stall=0 while rst=0.
REQ-025 Reset asserted mid-MEM_WAIT or mid-FLUSH SHALL abandon the state; no pending flush or stall survives.

Structure
REQ-026 SHALL take the state enum, scoreboard entry struct and REG_FILE_ADDR_LEN from shared package cpu_pkg.
REQ-027 SHALL contain one sub-module, sb_match, comparing one source against the three entries and returning per-stage hit bits.

Verification
REQ-028 Load R3 in EX, ID reads src1=3 with HAZARD_FWD_EN -> hazard_detected=1 for 1 cycle; next cycle EX valid=0.
REQ-029 ALU write R5, next instruction reads R5 without HAZARD_FWD_EN -> hazard_detected=1 for 3 consecutive cycles, then 0.
REQ-030 br_taken=1 in RUN, no hazard -> ifid_flush=1 for one cycle, state=FLUSH, then RUN.
REQ-031 mem_req=1, mem_ack at wait cycle 4 -> mem_stall=1 for 4 cycles, scoreboard unchanged, state back to RUN.
REQ-032 mem_req held, no ack, TIMEOUT_CYC=5 -> mem_timeout=1 after 5 wait cycles and stays 1 after ack.
REQ-033 rst=0 during MEM_WAIT -> same-cycle state=RUN, mem_stall=0, mem_timeout=0.
